// File: rtl/fft_stereo_sched_if.sv
// ---------------------------------------------------------------------------
// fft_stereo_sched_if
// Bundle of every non-clock signal between the stereo FFT scheduler, the two
// frame buffers, the FFT core and the downstream magnitude/display stage.
//
//   master : the scheduler (fft_stereo_sched)
//   slave  : the surroundings (buffers, FFT core, output consumer)
//
//   req_l/req_r          frame-ready levels from the L/R buffers
//   ack_l/ack_r          one-cycle release pulses back to the buffers
//   buf_sel, buf_raddr   buffer select (0=L, 1=R) and read address
//   buf_rdata_l/_r       buffer read data, one cycle after the address
//   fft_ibstart          block-start pulse into the core, with sample 0
//   fft_dire/fft_diim    real / imaginary input samples (imaginary is 0)
//   fft_rfib             core ready for an input block
//   fft_obstart          core output block start
//   fft_outvalid         core output valid
//   fft_except           core exception
//   out_ch, out_first    channel tag and qualified block start for outputs
//   busy, err            streaming indicator, sticky error
// ---------------------------------------------------------------------------
interface fft_stereo_sched_if #(
  parameter int AW = 11,
  parameter int DW = 16
);
  logic                 req_l;
  logic                 req_r;
  logic                 ack_l;
  logic                 ack_r;
  logic                 buf_sel;
  logic [AW-1:0]        buf_raddr;
  logic signed [DW-1:0] buf_rdata_l;
  logic signed [DW-1:0] buf_rdata_r;
  logic                 fft_ibstart;
  logic signed [DW-1:0] fft_dire;
  logic signed [DW-1:0] fft_diim;
  logic                 fft_rfib;
  logic                 fft_obstart;
  logic                 fft_outvalid;
  logic                 fft_except;
  logic                 out_ch;
  logic                 out_first;
  logic                 busy;
  logic                 err;

  modport master (
    input  req_l, req_r, buf_rdata_l, buf_rdata_r,
           fft_rfib, fft_obstart, fft_outvalid, fft_except,
    output ack_l, ack_r, buf_sel, buf_raddr,
           fft_ibstart, fft_dire, fft_diim,
           out_ch, out_first, busy, err
  );

  modport slave (
    output req_l, req_r, buf_rdata_l, buf_rdata_r,
           fft_rfib, fft_obstart, fft_outvalid, fft_except,
    input  ack_l, ack_r, buf_sel, buf_raddr,
           fft_ibstart, fft_dire, fft_diim,
           out_ch, out_first, busy, err
  );
endinterface

// File: rtl/fft_stereo_sched.sv
// ---------------------------------------------------------------------------
// fft_stereo_sched
// Time-shares one NPTS-point complex FFT core between the left and right
// frame buffers. A round-robin arbiter grants a ready buffer when the core
// can take a block, the granted frame is read out and streamed into the core
// with a block-start pulse on sample 0, and the buffer is released with an
// ack on the last sample. Each granted channel is queued in a small tag FIFO
// and popped on the core's output block start so results can be routed.
//
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   fft_stereo_sched_if.master (buffers, FFT core, output tagging)
// ---------------------------------------------------------------------------
module fft_stereo_sched #(
  parameter int NPTS = 2048,
  parameter int AW   = 11,
  parameter int DW   = 16,
  parameter int TAGD = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  fft_stereo_sched_if.master    bus
);

  localparam int CW = $clog2(TAGD + 1);
  localparam int PW = (TAGD > 1) ? $clog2(TAGD) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t               state;
  logic                 buf_sel;
  logic [AW-1:0]        raddr_p0;
  logic [AW-1:0]        cnt;
  logic                 ibstart;
  logic                 ack_l;
  logic                 ack_r;
  logic                 busy;
  logic                 pref_r;      // 1: R wins the next tie

  logic                 tag_mem [TAGD];
  logic [PW-1:0]        wp;
  logic [PW-1:0]        rp;
  logic [CW-1:0]        tag_cnt;
  logic                 ch_hold;
  logic                 err;

  logic                 tag_full;
  logic                 tag_empty;
  logic                 grant_ok;
  logic                 grant_ch;
  logic                 push;
  logic                 pop;
  logic                 vld_p1;
  logic signed [DW-1:0] dire_p1;

  // Address advance that parks on the last sample instead of wrapping.
  function automatic logic [AW-1:0] addr_sat_inc(input logic [AW-1:0] a);
    return (a == AW'(NPTS - 1)) ? a : a + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(TAGD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tag_full  = (tag_cnt == CW'(TAGD));
  assign tag_empty = (tag_cnt == '0);

  // Tie goes to the channel not granted last; a lone request wins outright.
  assign grant_ch = (bus.req_l && bus.req_r) ? pref_r : bus.req_r;
  assign grant_ok = (state == IDLE) && (bus.req_l || bus.req_r) &&
                    bus.fft_rfib && !tag_full;

  assign push = grant_ok;
  assign pop  = bus.fft_obstart && !tag_empty;

  // Control FSM: the grant is the only point where the core's readiness and
  // the tag space are checked; once a frame starts it always runs to the end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      buf_sel  <= 1'b0;
      raddr_p0 <= '0;
      cnt      <= '0;
      ibstart  <= 1'b0;
      ack_l    <= 1'b0;
      ack_r    <= 1'b0;
      busy     <= 1'b0;
      pref_r   <= 1'b0;
    end else begin
      ibstart <= 1'b0;
      ack_l   <= 1'b0;
      ack_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state    <= FILL;
            buf_sel  <= grant_ch;
            raddr_p0 <= '0;
            pref_r   <= ~grant_ch;
            busy     <= 1'b1;
          end
        end
        FILL: begin
          state    <= STREAM;
          raddr_p0 <= addr_sat_inc(raddr_p0);
          cnt      <= '0;
          ibstart  <= 1'b1;
        end
        STREAM: begin
          raddr_p0 <= addr_sat_inc(raddr_p0);
          cnt      <= cnt + 1'b1;
          // Raise the ack so it lands on the cycle carrying sample NPTS-1.
          if (cnt == AW'(NPTS - 2)) begin
            ack_l <= ~buf_sel;
            ack_r <= buf_sel;
          end
          if (cnt == AW'(NPTS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p0 -> p1: buffer returns the data for the address issued last cycle.
  // The buffer output is already registered, so the selected word is passed
  // straight through while streaming and forced to 0 otherwise.
  assign vld_p1  = (state == STREAM);
  assign dire_p1 = vld_p1 ? (buf_sel ? bus.buf_rdata_r : bus.buf_rdata_l) : '0;

  // Tag storage holds data only; occupancy and pointers carry the state.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wp] <= grant_ch;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp      <= '0;
      rp      <= '0;
      tag_cnt <= '0;
      ch_hold <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (push) wp <= ptr_inc(wp);
      if (pop) begin
        rp      <= ptr_inc(rp);
        ch_hold <= tag_mem[rp];
      end
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      // An output block with no matching grant means the tags are out of step.
      if (bus.fft_except || (bus.fft_obstart && tag_empty)) err <= 1'b1;
    end
  end

  assign bus.buf_sel     = buf_sel;
  assign bus.buf_raddr   = raddr_p0;
  assign bus.fft_ibstart = ibstart;
  assign bus.fft_dire    = dire_p1;
  assign bus.fft_diim    = '0;
  assign bus.ack_l       = ack_l;
  assign bus.ack_r       = ack_r;
  assign bus.busy        = busy;
  assign bus.err         = err;
  // Head of the FIFO is shown in the pop cycle itself, then held.
  assign bus.out_first   = pop;
  assign bus.out_ch      = pop ? tag_mem[rp] : ch_hold;

endmodule

// File: tb/tb_fft_stereo_sched.sv
module tb_fft_stereo_sched;
  localparam int NPTS = 2048;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int NV   = 7;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_stereo_sched_if #(.AW(AW), .DW(DW)) bus ();

  fft_stereo_sched #(.NPTS(NPTS), .AW(AW), .DW(DW), .TAGD(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [DW-1:0] mem_l [NPTS];
  logic [DW-1:0] mem_r [NPTS];

  always @(posedge clk) begin
    bus.buf_rdata_l <= mem_l[bus.buf_raddr];
    bus.buf_rdata_r <= mem_r[bus.buf_raddr];
  end

  int ackl_cnt = 0;
  int ackr_cnt = 0;
  always @(negedge clk) begin
    if (bus.ack_l) ackl_cnt++;
    if (bus.ack_r) ackr_cnt++;
  end

  typedef struct {
    int k;
    int dire;
    bit ib;
    bit ackl;
    bit busy;
  } fvec_t;

  fvec_t vec [NV];
  int n_pass  = 0;
  int n_total = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.fft_ibstart, bus.fft_dire, bus.fft_diim, bus.buf_raddr,
                bus.buf_sel, bus.ack_l, bus.ack_r, bus.out_ch, bus.out_first,
                bus.busy, bus.err});
  endfunction

  task automatic do_reset;
    rstn             = 1'b0;
    bus.req_l        = 1'b0;
    bus.req_r        = 1'b0;
    bus.fft_rfib     = 1'b0;
    bus.fft_obstart  = 1'b0;
    bus.fft_outvalid = 1'b0;
    bus.fft_except   = 1'b0;
    tick;
    tick;
    chk("reset outputs", outs(), 64'd0);
    rstn = 1'b1;
    tick;
  endtask

  task automatic wait_ib(input int budget, output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (!bus.fft_ibstart && n < budget);
  endtask

  initial begin
    int n, idx, diim_bad, extra, bad, base_l, base_r;

    for (int i = 0; i < NPTS; i++) begin
      mem_l[i] = 16'(i);
      mem_r[i] = 16'(16'h4000 + i);
    end

    vec[0] = '{0,    0,    1'b1, 1'b0, 1'b1};
    vec[1] = '{1,    1,    1'b0, 1'b0, 1'b1};
    vec[2] = '{500,  500,  1'b0, 1'b0, 1'b1};
    vec[3] = '{1000, 1000, 1'b0, 1'b0, 1'b1};
    vec[4] = '{2046, 2046, 1'b0, 1'b0, 1'b1};
    vec[5] = '{2047, 2047, 1'b0, 1'b1, 1'b1};
    vec[6] = '{2048, 0,    1'b0, 1'b0, 1'b0};

    // Single L frame; the request drops right after the grant.
    do_reset;
    base_l = ackl_cnt;
    base_r = ackr_cnt;
    bus.req_l    = 1'b1;
    bus.fft_rfib = 1'b1;
    tick;
    chk("fill busy", 64'(bus.busy), 64'd1);
    chk("fill ibstart", 64'(bus.fft_ibstart), 64'd0);
    chk("fill raddr", 64'(bus.buf_raddr), 64'd0);
    chk("fill sel", 64'(bus.buf_sel), 64'd0);
    bus.req_l = 1'b0;
    idx = 0;
    diim_bad = 0;
    for (int k = 0; k <= NPTS; k++) begin
      tick;
      if (bus.fft_diim !== '0) diim_bad++;
      if (idx < NV && vec[idx].k == k) begin
        chk($sformatf("L k=%0d dire", k), 64'(bus.fft_dire), 64'(vec[idx].dire));
        chk($sformatf("L k=%0d ibstart", k), 64'(bus.fft_ibstart), 64'(vec[idx].ib));
        chk($sformatf("L k=%0d ack_l", k), 64'(bus.ack_l), 64'(vec[idx].ackl));
        chk($sformatf("L k=%0d busy", k), 64'(bus.busy), 64'(vec[idx].busy));
        idx++;
      end
    end
    chk("L diim nonzero cycles", 64'(diim_bad), 64'd0);
    chk("L ack_l pulses", 64'(ackl_cnt - base_l), 64'd1);
    chk("L ack_r pulses", 64'(ackr_cnt - base_r), 64'd0);

    // Both requests held from reset: L,R,L,R, then the full tag FIFO blocks.
    do_reset;
    bus.req_l    = 1'b1;
    bus.req_r    = 1'b1;
    bus.fft_rfib = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ib(NPTS + 50, n);
      chk($sformatf("rr ibstart %0d seen", i), 64'(bus.fft_ibstart), 64'd1);
      chk($sformatf("rr grant %0d sel", i), 64'(bus.buf_sel), 64'(i % 2));
      if (i == 0) chk("rr first latency", 64'(n), 64'd2);
      else        chk($sformatf("rr spacing %0d", i), 64'(n), 64'(NPTS + 2));
    end
    extra = 0;
    for (int i = 0; i < NPTS + 40; i++) begin
      tick;
      if (bus.fft_ibstart) extra++;
    end
    chk("full fifo extra grants", 64'(extra), 64'd0);
    chk("full fifo busy", 64'(bus.busy), 64'd0);

    // Tag routing: first output block is L, second R.
    bus.fft_obstart = 1'b1;
    #1;
    chk("pop1 out_first", 64'(bus.out_first), 64'd1);
    chk("pop1 out_ch", 64'(bus.out_ch), 64'd0);
    tick;
    bus.fft_obstart = 1'b0;
    #1;
    chk("hold out_first", 64'(bus.out_first), 64'd0);
    chk("hold out_ch", 64'(bus.out_ch), 64'd0);
    wait_ib(10, n);
    chk("fifth ibstart seen", 64'(bus.fft_ibstart), 64'd1);
    chk("fifth latency after pop", 64'(n), 64'd2);
    chk("fifth sel", 64'(bus.buf_sel), 64'd0);
    bus.req_l = 1'b0;
    bus.req_r = 1'b0;
    tick;
    bus.fft_obstart = 1'b1;
    #1;
    chk("pop2 out_first", 64'(bus.out_first), 64'd1);
    chk("pop2 out_ch", 64'(bus.out_ch), 64'd1);
    tick;
    bus.fft_obstart = 1'b0;
    tick;
    bus.fft_obstart = 1'b1;
    #1;
    chk("pop3 out_ch", 64'(bus.out_ch), 64'd0);
    tick;
    bus.fft_obstart = 1'b0;
    chk("no err after pops", 64'(bus.err), 64'd0);

    // Backpressure: rfib low holds off the R grant.
    do_reset;
    bus.req_r    = 1'b1;
    bus.fft_rfib = 1'b0;
    bad = 0;
    repeat (10) begin
      tick;
      if (bus.busy || bus.fft_ibstart) bad++;
    end
    chk("rfib low activity", 64'(bad), 64'd0);
    bus.fft_rfib = 1'b1;
    tick;
    chk("R grant busy", 64'(bus.busy), 64'd1);
    chk("R grant sel", 64'(bus.buf_sel), 64'd1);
    chk("R grant ibstart early", 64'(bus.fft_ibstart), 64'd0);
    tick;
    chk("R ibstart", 64'(bus.fft_ibstart), 64'd1);
    chk("R sample0", 64'(bus.fft_dire), 64'h4000);
    bus.fft_rfib = 1'b0;
    bus.req_r    = 1'b0;
    n = 0;
    do begin
      tick;
      n++;
    end while (!bus.ack_r && n < NPTS + 50);
    chk("R ack_r seen", 64'(bus.ack_r), 64'd1);
    chk("R ack position", 64'(n), 64'(NPTS - 1));
    chk("R last sample", 64'(bus.fft_dire), 64'h47FF);

    // Errors: core exception is sticky.
    chk("err before except", 64'(bus.err), 64'd0);
    bus.fft_except = 1'b1;
    tick;
    bus.fft_except = 1'b0;
    chk("err after except", 64'(bus.err), 64'd1);
    repeat (5) tick;
    chk("err sticky", 64'(bus.err), 64'd1);

    // Output block start with no tag queued.
    do_reset;
    bus.fft_obstart = 1'b1;
    #1;
    chk("empty pop out_first", 64'(bus.out_first), 64'd0);
    chk("empty pop out_ch", 64'(bus.out_ch), 64'd0);
    tick;
    bus.fft_obstart = 1'b0;
    chk("empty pop err", 64'(bus.err), 64'd1);

    // Asynchronous reset at sample 1000, then the frame is re-granted.
    do_reset;
    bus.req_l    = 1'b1;
    bus.fft_rfib = 1'b1;
    wait_ib(10, n);
    chk("mid L latency", 64'(n), 64'd2);
    repeat (1000) tick;
    chk("mid sample 1000", 64'(bus.fft_dire), 64'd1000);
    base_l = ackl_cnt;
    #2;
    rstn = 1'b0;
    #1;
    chk("async reset outputs", outs(), 64'd0);
    tick;
    tick;
    rstn = 1'b1;
    n = 0;
    do begin
      tick;
      n++;
    end while (!bus.busy && n < 10);
    chk("regrant after reset", 64'(n), 64'd1);
    chk("regrant raddr", 64'(bus.buf_raddr), 64'd0);
    tick;
    chk("restart ibstart", 64'(bus.fft_ibstart), 64'd1);
    chk("restart sample0", 64'(bus.fft_dire), 64'd0);
    chk("no ack across reset", 64'(ackl_cnt - base_l), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
